// File: rtl/serv_wb_mem_pkg.sv
// Shared types and helpers for the SERV Wishbone data-memory responder.
package serv_wb_mem_pkg;

  // Width of the wait-state counter; holds WAIT values 0..15.
  localparam int WCW = 4;

  // Responder handshake states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  // Expand a 4-bit byte-lane select into a 32-bit bit mask (sel[n] -> bits [8n+7:8n]).
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] mask;
    mask = 32'h0000_0000;
    for (int n = 0; n < 4; n++) begin
      mask[8*n +: 8] = {8{sel[n]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/serv_wb_mem_bank.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module serv_wb_mem_bank
  import serv_wb_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_be,
  input  logic          i_we,
  input  logic          i_re,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;
  logic [31:0] mask_s;

  assign mask_s  = byte_mask(i_be);
  assign o_rdata = rdata_r;

  // Byte-lane masked write: lanes with be=0 keep their previous contents.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_r[i_addr] <= (mem_r[i_addr] & ~mask_s) | (i_wdata & mask_s);
    end
  end

  // Registered read port; holds its value when no read is issued.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      rdata_r <= mem_r[i_addr];
    end
  end

endmodule

// File: rtl/serv_wb_mem_resp.sv
// Wishbone data-bus responder for the SERV core: FSM, wait-state counter and
// out-of-range decode around a byte-lane RAM bank.
module serv_wb_mem_resp
  import serv_wb_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT  = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack
);

  localparam int             IW        = $clog2(DEPTH);
  localparam logic [WCW-1:0] WAIT_L    = WCW'(WAIT);
  localparam bit             ZERO_WAIT = (WAIT == 0);

  state_e         state_r;
  logic [WCW-1:0] cnt_r;
  logic           ack_r;
  logic           rdt_zero_r;   // masks read data after reset and after an OOR read

  logic [IW-1:0]  idx_s;
  logic           oor_s;
  logic           commit_s;
  logic           bank_we_s;
  logic           bank_re_s;
  logic [31:0]    bank_rdata_s;
  logic           unused_s;

  assign idx_s     = i_wb_adr[IW+1:2];
  assign oor_s     = |i_wb_adr[31:IW+2];
  assign unused_s  = ^i_wb_adr[1:0];   // byte offset is trapped by the initiator
  assign bank_we_s = commit_s &  i_wb_we & ~oor_s;
  assign bank_re_s = commit_s & ~i_wb_we & ~oor_s;

  assign o_wb_ack  = ack_r;
  assign o_wb_rdt  = bank_rdata_s & {32{~rdt_zero_r}};

  // Commit strobe: true on the edge that moves the FSM into ACK.
  always_comb begin
    commit_s = 1'b0;
    case (state_r)
      S_IDLE:  commit_s = i_wb_cyc & ZERO_WAIT;
      S_WAIT:  commit_s = i_wb_cyc & (cnt_r == WCW'(1));
      default: commit_s = 1'b0;
    endcase
  end

  // Handshake FSM with wait counter, registered ack and read-data mask.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= S_IDLE;
      cnt_r      <= {WCW{1'b0}};
      ack_r      <= 1'b0;
      rdt_zero_r <= 1'b1;
    end else begin
      ack_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (i_wb_cyc) begin
            cnt_r   <= WAIT_L;
            state_r <= ZERO_WAIT ? S_ACK : S_WAIT;
            ack_r   <= ZERO_WAIT;
          end
        end
        S_WAIT: begin
          if (!i_wb_cyc) begin
            // Initiator aborted: drop the request without side effects.
            state_r <= S_IDLE;
            cnt_r   <= {WCW{1'b0}};
          end else begin
            cnt_r <= cnt_r - WCW'(1);
            if (cnt_r == WCW'(1)) begin
              state_r <= S_ACK;
              ack_r   <= 1'b1;
            end
          end
        end
        S_ACK: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= {WCW{1'b0}};
        end
      endcase
      if (commit_s && !i_wb_we) begin
        rdt_zero_r <= oor_s;
      end
    end
  end

  serv_wb_mem_bank #(
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_bank (
    .i_clk   (i_clk),
    .i_addr  (idx_s),
    .i_wdata (i_wb_dat),
    .i_be    (i_wb_sel),
    .i_we    (bank_we_s),
    .i_re    (bank_re_s),
    .o_rdata (bank_rdata_s)
  );

endmodule

// File: tb/tb_serv_wb_mem_resp.sv
// Directed bench for serv_wb_mem_resp: one instance with WAIT=0, one with WAIT=3.
module tb_serv_wb_mem_resp;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc0;
  logic        cyc3;
  logic [31:0] rdt0;
  logic [31:0] rdt3;
  logic        ack0;
  logic        ack3;

  int checks = 0;
  int errors = 0;

  serv_wb_mem_resp #(.DEPTH(256), .WAIT(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc0), .o_wb_rdt(rdt0), .o_wb_ack(ack0)
  );

  serv_wb_mem_resp #(.DEPTH(256), .WAIT(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc3), .o_wb_rdt(rdt3), .o_wb_ack(ack3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on dut0 (d3=0, ack after 1 edge) or dut3 (d3=1, ack after 4 edges).
  task automatic txn(input bit d3, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input string tag, output logic [31:0] rd);
    int lat;
    lat = d3 ? 4 : 1;
    @(negedge clk);
    adr = a; dat = d; sel = s; we = w;
    if (d3) cyc3 = 1'b1; else cyc0 = 1'b1;
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      if (i < lat) check({tag, "_noack"}, {31'd0, d3 ? ack3 : ack0}, 32'd0);
      else         check({tag, "_ack"},   {31'd0, d3 ? ack3 : ack0}, 32'd1);
    end
    rd = d3 ? rdt3 : rdt0;
    @(negedge clk);
    cyc0 = 1'b0; cyc3 = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, d3 ? ack3 : ack0}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        seen;
    rst_n = 1'b0; adr = 32'd0; dat = 32'd0; sel = 4'd0; we = 1'b0; cyc0 = 1'b0; cyc3 = 1'b0;

    // Reset state
    #2;
    check("rst_ack0", {31'd0, ack0}, 32'd0);
    check("rst_rdt0", rdt0, 32'd0);
    check("rst_ack3", {31'd0, ack3}, 32'd0);
    check("rst_rdt3", rdt3, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full-word write/read, WAIT=0
    txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "w_full", rd);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, "r_full", rd);
    check("rd_full", rd, 32'hDEAD_BEEF);

    // Byte and half-word lanes
    txn(1'b0, 1'b1, 32'h10, 32'h0000_00AA, 4'h1, "w_byte", rd);
    txn(1'b0, 1'b1, 32'h10, 32'h5566_0000, 4'hC, "w_half", rd);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, "r_lanes", rd);
    check("rd_lanes", rd, 32'h5566_BEAA);

    // Read data holds across a write
    txn(1'b0, 1'b1, 32'h14, 32'h7777_7777, 4'hF, "w_hold", rd);
    check("rdt_hold", rdt0, 32'h5566_BEAA);

    // cyc held through ACK: next ack comes two cycles later (1,0,1)
    @(negedge clk);
    adr = 32'h14; we = 1'b0; cyc0 = 1'b1;
    @(posedge clk); #1; check("b2b_ack1", {31'd0, ack0}, 32'd1);
    check("b2b_rdt1", rdt0, 32'h7777_7777);
    @(posedge clk); #1; check("b2b_gap",  {31'd0, ack0}, 32'd0);
    @(posedge clk); #1; check("b2b_ack2", {31'd0, ack0}, 32'd1);
    @(negedge clk); cyc0 = 1'b0;
    @(posedge clk); #1; check("b2b_end",  {31'd0, ack0}, 32'd0);

    // Out of range: write dropped without aliasing, read returns 0
    txn(1'b0, 1'b1, 32'h0, 32'h1111_1111, 4'hF, "w_zero", rd);
    txn(1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, "w_oor", rd);
    txn(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, "r_zero", rd);
    check("rd_noalias", rd, 32'h1111_1111);
    txn(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, "r_oor", rd);
    check("rd_oor", rd, 32'h0);

    // Wait states, WAIT=3
    txn(1'b1, 1'b1, 32'h4, 32'hCAFE_F00D, 4'hF, "w3_4", rd);
    txn(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, "r3_4", rd);
    check("rd3_4", rd, 32'hCAFE_F00D);

    // Abort during WAIT
    txn(1'b1, 1'b1, 32'h8, 32'h0BAD_C0DE, 4'hF, "w3_8", rd);
    @(negedge clk);
    adr = 32'h8; dat = 32'h1234_5678; sel = 4'hF; we = 1'b1; cyc3 = 1'b1;
    @(negedge clk);
    cyc3 = 1'b0; we = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack3) seen = 1'b1;
    end
    check("abort_noack", {31'd0, seen}, 32'd0);
    check("abort_rdt", rdt3, 32'hCAFE_F00D);
    txn(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, "r3_8", rd);
    check("rd_abort", rd, 32'h0BAD_C0DE);

    // Reset during WAIT: outputs clear at once, RAM untouched
    txn(1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, "w3_10", rd);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, "r3_10", rd);
    check("rd3_10", rd, 32'hA5A5_A5A5);
    @(negedge clk);
    adr = 32'h10; dat = 32'hFFFF_0000; sel = 4'hF; we = 1'b1; cyc3 = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rstw_ack3", {31'd0, ack3}, 32'd0);
    check("rstw_rdt3", rdt3, 32'h0);
    check("rstw_rdt0", rdt0, 32'h0);
    cyc3 = 1'b0; we = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, "r3_post", rd);
    check("rd3_post", rd, 32'hA5A5_A5A5);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, "r0_post", rd);
    check("rd0_post", rd, 32'h5566_BEAA);

    // Reset during ACK: the committed write survives
    @(negedge clk);
    adr = 32'h20; dat = 32'h1357_2468; sel = 4'hF; we = 1'b1; cyc0 = 1'b1;
    @(posedge clk); #1;
    check("rsta_ack", {31'd0, ack0}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rsta_clr", {31'd0, ack0}, 32'd0);
    cyc0 = 1'b0; we = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, "r_kept", rd);
    check("rd_kept", rd, 32'h1357_2468);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
